// File: rtl/line_buf_ctrl_pkg.sv
// Shared types and default sizes for the 3-row line buffer.
package line_buf_ctrl_pkg;

    localparam int unsigned WIDTH_DEF  = 8;
    localparam int unsigned LINE_W_DEF = 640;

    // PRIME0/PRIME1 fill the two line RAMs; STREAM emits 3-row columns.
    typedef enum logic [1:0] {
        PRIME0 = 2'd0,
        PRIME1 = 2'd1,
        STREAM = 2'd2
    } lb_state_e;

endpackage

// File: rtl/sync_ram_block.sv
// Single-port synchronous RAM, read-first; output register holds when disabled.
module sync_ram_block #(
    parameter int unsigned WIDTH_P = 8,
    parameter int unsigned DEPTH_P = 640,
    localparam int unsigned ADDR_W = $clog2(DEPTH_P)
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               en_i,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [WIDTH_P-1:0] wdata_i,
    output logic [WIDTH_P-1:0] rdata_o
);

    logic [WIDTH_P-1:0] mem [DEPTH_P];
    logic [WIDTH_P-1:0] rdata_q;
    logic [WIDTH_P-1:0] rdata_d;

    // Read returns pre-write contents; hold the last read when not enabled.
    always_comb begin
        rdata_d = rdata_q;
        if (en_i) begin
            rdata_d = mem[addr_i];
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    // Read data register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_buf_ctrl.sv
// Two-line buffer producing {top, mid, bottom} pixel columns from a raster stream.
module line_buf_ctrl
    import line_buf_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH_P  = WIDTH_DEF,
    parameter int unsigned LINE_W_P = LINE_W_DEF,
    localparam int unsigned COL_W   = $clog2(LINE_W_P)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clear_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH_P-1:0]   data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [3*WIDTH_P-1:0] data_o,
    output logic                 last_o
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W_P - 1);

    lb_state_e          state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               sel_q, sel_d;
    logic               sel_cap_q, sel_cap_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [WIDTH_P-1:0] bot_q, bot_d;

    logic               accept_c;
    logic               wrap_c;
    logic               ram_en_c;
    logic [WIDTH_P-1:0] rd0, rd1;

    // Handshake: single output stage, refill while the column drains.
    assign ready_o  = !valid_q || ready_i;
    assign accept_c = valid_i && ready_o;
    assign wrap_c   = (col_q == COL_LAST);
    assign ram_en_c = accept_c && !clear_i;

    // Next-state and datapath control; clear overrides any accept.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        sel_d     = sel_q;
        sel_cap_d = sel_cap_q;
        valid_d   = valid_q;
        last_d    = last_q;
        bot_d     = bot_q;

        if (clear_i) begin
            state_d = PRIME0;
            col_d   = '0;
            sel_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
            if (accept_c) begin
                col_d     = wrap_c ? '0 : col_q + COL_W'(1);
                sel_d     = wrap_c ? !sel_q : sel_q;
                sel_cap_d = sel_q;
                bot_d     = data_i;
                last_d    = wrap_c;
                valid_d   = (state_q == STREAM);
                case (state_q)
                    PRIME0:  if (wrap_c) state_d = PRIME1;
                    PRIME1:  if (wrap_c) state_d = STREAM;
                    STREAM:  state_d = STREAM;
                    default: state_d = PRIME0;
                endcase
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= PRIME0;
            col_q     <= '0;
            sel_q     <= 1'b0;
            sel_cap_q <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            bot_q     <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            sel_q     <= sel_d;
            sel_cap_q <= sel_cap_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            bot_q     <= bot_d;
        end
    end

    // L0: written when sel_q == 0 (it then holds line n-2).
    sync_ram_block #(
        .WIDTH_P (WIDTH_P),
        .DEPTH_P (LINE_W_P)
    ) u_ram_l0 (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .en_i    (ram_en_c),
        .we_i    (!sel_q),
        .addr_i  (col_q),
        .wdata_i (data_i),
        .rdata_o (rd0)
    );

    // L1: written when sel_q == 1.
    sync_ram_block #(
        .WIDTH_P (WIDTH_P),
        .DEPTH_P (LINE_W_P)
    ) u_ram_l1 (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .en_i    (ram_en_c),
        .we_i    (sel_q),
        .addr_i  (col_q),
        .wdata_i (data_i),
        .rdata_o (rd1)
    );

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign data_o  = {(sel_cap_q ? rd1 : rd0), (sel_cap_q ? rd0 : rd1), bot_q};

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed and randomised checks of line_buf_ctrl with 4-pixel lines.
module tb_line_buf_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned LW = 4;

    logic          clk_i;
    logic          rstn_i;
    logic          clear_i;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  data_i;
    logic          valid_o;
    logic          ready_i;
    logic [3*W-1:0] data_o;
    logic          last_o;

    int n_vec;
    int n_err;

    line_buf_ctrl #(
        .WIDTH_P  (W),
        .LINE_W_P (LW)
    ) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clear_i (clear_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .last_o  (last_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] col3(input int a, input int b, input int c);
        return {8'(a), 8'(b), 8'(c)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs, let them settle, then advance past one rising edge.
    task automatic cyc(input logic v, input int d, input logic r, input logic c);
        valid_i = v;
        data_i  = 8'(d);
        ready_i = r;
        clear_i = c;
        #1;
        @(posedge clk_i);
        #1;
    endtask

    // Push pixel p with ready_i=1; continuous lines give column {p-8, p-4, p}.
    task automatic push(input int p, input logic ev);
        cyc(1'b1, p, 1'b1, 1'b0);
        chk($sformatf("valid_p%0d", p), 32'(valid_o), 32'(ev));
        if (ev) begin
            chk($sformatf("data_p%0d", p), 32'(data_o), 32'(col3(p - 8, p - 4, p)));
            chk($sformatf("last_p%0d", p), 32'(last_o), 32'((p % 4) == 0));
        end
    endtask

    logic [7:0]  vals [20];
    logic [24:0] exq [$];
    logic [24:0] exp_e;
    int          acc;
    int          cnt;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rstn_i  = 1'b0;
        clear_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        #1;
        chk("rst_ready", 32'(ready_o), 32'd1);
        #21;
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data",  32'(data_o),  32'd0);
        chk("rst_last",  32'(last_o),  32'd0);
        chk("rst_ready2", 32'(ready_o), 32'd1);

        // Priming and first two streamed lines.
        for (int p = 1; p <= 8; p++)  push(p, 1'b0);
        for (int p = 9; p <= 16; p++) push(p, 1'b1);
        push(17, 1'b1);

        // Backpressure: output frozen, no accept, no RAM write.
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            data_i  = 8'd18;
            ready_i = 1'b0;
            #1;
            chk("stall_ready", 32'(ready_o), 32'd0);
            @(posedge clk_i);
            #1;
            chk("stall_valid", 32'(valid_o), 32'd1);
            chk("stall_data",  32'(data_o),  32'(col3(9, 13, 17)));
        end
        push(18, 1'b1);
        push(19, 1'b1);
        push(20, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b0);
        chk("idle_valid", 32'(valid_o), 32'd0);
        push(21, 1'b1);
        push(22, 1'b1);

        // Clear at column 2 with a simultaneous pixel: pixel dropped, re-prime.
        cyc(1'b1, 99, 1'b1, 1'b1);
        chk("clear_valid", 32'(valid_o), 32'd0);
        for (int p = 101; p <= 108; p++) push(p, 1'b0);
        for (int p = 109; p <= 110; p++) push(p, 1'b1);

        // Asynchronous reset mid-line between edges.
        valid_i = 1'b0;
        #2;
        rstn_i = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_data",  32'(data_o),  32'd0);
        chk("arst_last",  32'(last_o),  32'd0);
        chk("arst_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int p = 201; p <= 208; p++) push(p, 1'b0);
        for (int p = 209; p <= 212; p++) push(p, 1'b1);

        // Random valid/ready over three frames against a queue model.
        for (int f = 0; f < 3; f++) begin
            cyc(1'b0, 0, 1'b1, 1'b1);
            exq.delete();
            acc = 0;
            cnt = 0;
            while ((acc < 20 || exq.size() > 0) && cnt < 600) begin
                valid_i = (acc < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
                data_i  = 8'(acc * 7 + 3 + f * 60);
                ready_i = ($urandom_range(0, 3) != 0);
                clear_i = 1'b0;
                #1;
                if (valid_o && ready_i) begin
                    if (exq.size() == 0) begin
                        chk("rnd_extra_col", 32'(valid_o), 32'd0);
                    end else begin
                        exp_e = exq.pop_front();
                        chk($sformatf("rnd_f%0d_col", f), 32'({last_o, data_o}), 32'(exp_e));
                    end
                end
                if (valid_i && ready_o) begin
                    vals[acc] = data_i;
                    if (acc >= 8) begin
                        exq.push_back({((acc % 4) == 3), vals[acc - 8], vals[acc - 4], data_i});
                    end
                    acc++;
                end
                @(posedge clk_i);
                #1;
                cnt++;
            end
            chk($sformatf("rnd_f%0d_accepts", f), 32'(acc), 32'd20);
            chk($sformatf("rnd_f%0d_drain", f), 32'(exq.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
